load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory stage directly downstream of the CPU execute stage. It accepts one RV32I load or store request per handshake and owns the data RAM. It performs byte, half and word accesses with lane steering, and sign- or zero-extends load data. It returns a registered writeback (rd, data) or an error pulse for misaligned, out-of-range or illegal accesses.

Parameters:
MEM_WORDS, 256, depth of the data RAM in 32-bit words; byte address space is 4*MEM_WORDS.
ADDR_W, 32, width of the request byte address.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  execute stage presents a request.
req_ready  out  1  unit can accept; high only in IDLE.
req_is_store  in  1  1 = store (SB/SH/SW), 0 = load.
req_funct3  in  3  RV32I funct3 of the load/store.
req_addr  in  ADDR_W  byte address (rs1 + imm, already computed upstream).
req_wdata  in  32  store data (rs2 value).
req_rd  in  5  load destination register.
wb_valid  out  1  one-cycle pulse: load data valid.
wb_rd  out  5  destination register for wb_data.
wb_data  out  32  extended load result.
store_done  out  1  one-cycle pulse: store committed.
err_valid  out  1  one-cycle pulse: request rejected, no memory side effect.
err_addr  out  ADDR_W  faulting byte address, valid with err_valid.

Behaviour:
- Reset: req_ready=1 after reset deasserts. wb_valid, store_done and err_valid are 0. wb_rd, wb_data and err_addr are 0. FSM is IDLE. RAM contents are NOT cleared.
- Accept: a request is accepted in cycle N when req_valid && req_ready. All request fields are sampled at N.
- FSM states: IDLE, LOAD_DATA.
  - IDLE -> LOAD_DATA on an accepted legal load.
  - LOAD_DATA -> IDLE unconditionally.
  - Stores and errors stay in IDLE.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal.
- Error checks, evaluated at accept; any of these raises an error:
  - Illegal funct3.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[ADDR_W-1:2] >= MEM_WORDS.
- Error response: err_valid=1 and err_addr=req_addr in N+1. No RAM write, no wb_valid. Ready stays high.
- Store: the RAM byte-write happens at the N edge. store_done=1 in N+1. Back-to-back stores are allowed every cycle.
  - SB: byte lane addr[1:0] receives wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} receive wdata[15:0].
  - SW: all four lanes written.
- Load latency is 2:
  - N: RAM read issued.
  - N+1: state LOAD_DATA, RAM dout valid, req_ready=0. Lane select and extension happen here, and the result is registered.
  - N+2: wb_valid=1 with wb_rd and wb_data. State is IDLE again, so req_ready=1 in N+2.
  - Maximum sustained rate is one load per 2 cycles.
- Extension:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-fill.
  - LW passes the word through.
- Load with rd=0: the access is performed and wb_valid is asserted with wb_rd=0. The register file discards it.
- Reset in LOAD_DATA: return to IDLE. No wb_valid in the following cycle.
- Reset in the same cycle as req_valid: the request is dropped, with no write and no response.
- Pulse outputs never overlap. At most one of wb_valid, store_done, err_valid is high in any cycle.

Decomposition:
- Shared package/header rv32i_defs, holding:
  - opcode constants (LOAD 0000011, STORE 0100011);
  - load/store funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the LSU state encoding;
  - a 4-bit byte-strobe width constant.
- One sub-module, data_ram: MEM_WORDS x 32, synchronous 1-cycle read, per-byte write enable (4 strobes), no reset.
- Strobe generation and load formatting stay in load_store_unit.

Test Plan:
1. SW 0x12345678 @0x10, then LW @0x10 rd=5 -> store_done at N+1; wb_valid at N+2 with rd=5, data=0x12345678.
2. SB 0xAA @0x13, then:
   - LB @0x13 -> 0xFFFFFFAA;
   - LBU @0x13 -> 0x000000AA;
   - LW @0x10 -> 0xAA345678.
3. SH 0xBEEF @0x12, then LH @0x12 -> 0xFFFFBEEF and LHU @0x12 -> 0x0000BEEF.
4. Misaligned and out-of-range:
   - LW @0x11 -> err_valid at N+1 with err_addr=0x11, no wb_valid;
   - SH @0x401 -> err;
   - SW @0x400 (MEM_WORDS=256) -> err, and RAM unchanged.
5. req_valid held high with two LWs back-to-back -> req_ready=0 at N+1, second accepted at N+2, second wb_valid at N+4.
6. Reset asserted during LOAD_DATA -> no wb_valid follows, req_ready=1 after reset. A following LW returns the pre-reset RAM contents.

Source files
------------

// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I load/store definitions: opcodes, funct3 codes, LSU state
// encoding and the captured-load context used by the load/store unit.
package rv32i_defs;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int BYTE_STROBE_W = 4;

  localparam logic [0:0] LSU_IDLE      = 1'b0;
  localparam logic [0:0] LSU_LOAD_DATA = 1'b1;

  // Everything the formatting stage needs once the RAM word comes back.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] offset;
    logic [4:0] rd;
  } load_ctx_t;

  function automatic logic isLegalFunct3(input logic isStore, input logic [2:0] funct3);
    if (isStore) begin
      return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end
    return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_store_unit_data_ram.sv
// Word-organised data RAM with per-byte write strobes and a registered
// (one-cycle) read port; contents are deliberately not reset.
module data_ram
  import rv32i_defs::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int RAM_AW    = $clog2(MEM_WORDS)
) (
  input  logic                     i_clk,
  input  logic [RAM_AW-1:0]        i_addr,
  input  logic [BYTE_STROBE_W-1:0] i_we,
  input  logic [31:0]              i_wdata,
  input  logic                     i_re,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < BYTE_STROBE_W; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: validates load/store requests, steers store bytes into
// the data RAM and formats/extends load data into a registered writeback.
module load_store_unit
  import rv32i_defs::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              store_done,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(MEM_WORDS);

  logic [0:0]               r_state;
  load_ctx_t                r_loadCtx;
  logic                     r_wbValid;
  logic [4:0]               r_wbRd;
  logic [31:0]              r_wbData;
  logic                     r_storeDone;
  logic                     r_errValid;
  logic [ADDR_W-1:0]        r_errAddr;

  logic                     w_accept;
  logic                     w_funct3Ok;
  logic                     w_misaligned;
  logic                     w_outOfRange;
  logic                     w_reqErr;
  logic                     w_doStore;
  logic                     w_doLoad;
  logic [BYTE_STROBE_W-1:0] w_strobe;
  logic [BYTE_STROBE_W-1:0] w_ramWe;
  logic [31:0]              w_storeData;
  logic [31:0]              w_ramRdata;
  logic [7:0]               w_loadByte;
  logic [15:0]              w_loadHalf;
  logic [31:0]              w_loadResult;

  assign req_ready = (r_state == LSU_IDLE);

  // A request arriving with reset is dropped outright.
  assign w_accept     = req_valid && req_ready && !reset;
  assign w_funct3Ok   = isLegalFunct3(req_is_store, req_funct3);
  assign w_outOfRange = ({2'b00, req_addr[ADDR_W-1:2]} >= LP_DEPTH);

  always_comb begin
    w_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_reqErr  = !w_funct3Ok || w_misaligned || w_outOfRange;
  assign w_doStore = w_accept && req_is_store && !w_reqErr;
  assign w_doLoad  = w_accept && !req_is_store && !w_reqErr;

  // Replicate narrow store data across lanes so the strobes alone pick the target bytes.
  always_comb begin
    w_strobe    = '0;
    w_storeData = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_strobe    = 4'b0001 << req_addr[1:0];
        w_storeData = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_strobe    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_storeData = {2{req_wdata[15:0]}};
      end
      default: begin
        w_strobe    = 4'b1111;
        w_storeData = req_wdata;
      end
    endcase
  end

  assign w_ramWe = w_doStore ? w_strobe : '0;

  data_ram #(
    .MEM_WORDS (MEM_WORDS),
    .RAM_AW    (RAM_AW)
  ) u_data_ram (
    .i_clk   (clk),
    .i_addr  (req_addr[RAM_AW+1:2]),
    .i_we    (w_ramWe),
    .i_wdata (w_storeData),
    .i_re    (w_doLoad),
    .o_rdata (w_ramRdata)
  );

  always_comb begin
    w_loadByte   = '0;
    w_loadResult = w_ramRdata;
    case (r_loadCtx.offset)
      2'd0:    w_loadByte = w_ramRdata[7:0];
      2'd1:    w_loadByte = w_ramRdata[15:8];
      2'd2:    w_loadByte = w_ramRdata[23:16];
      default: w_loadByte = w_ramRdata[31:24];
    endcase
    w_loadHalf = r_loadCtx.offset[1] ? w_ramRdata[31:16] : w_ramRdata[15:0];
    case (r_loadCtx.funct3)
      F3_LB:   w_loadResult = {{24{w_loadByte[7]}}, w_loadByte};
      F3_LBU:  w_loadResult = {24'b0, w_loadByte};
      F3_LH:   w_loadResult = {{16{w_loadHalf[15]}}, w_loadHalf};
      F3_LHU:  w_loadResult = {16'b0, w_loadHalf};
      default: w_loadResult = w_ramRdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= LSU_IDLE;
      r_loadCtx <= '0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_doLoad) begin
            r_state   <= LSU_LOAD_DATA;
            r_loadCtx <= '{funct3: req_funct3, offset: req_addr[1:0], rd: req_rd};
          end
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  // Response registers; only one pulse source can be active because loads block acceptance for a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbValid   <= 1'b0;
      r_wbRd      <= '0;
      r_wbData    <= '0;
      r_storeDone <= 1'b0;
      r_errValid  <= 1'b0;
      r_errAddr   <= '0;
    end else begin
      r_wbValid   <= (r_state == LSU_LOAD_DATA);
      r_storeDone <= w_doStore;
      r_errValid  <= w_accept && w_reqErr;
      if (r_state == LSU_LOAD_DATA) begin
        r_wbRd   <= r_loadCtx.rd;
        r_wbData <= w_loadResult;
      end
      if (w_accept && w_reqErr) begin
        r_errAddr <= req_addr;
      end
    end
  end

  assign wb_valid   = r_wbValid;
  assign wb_rd      = r_wbRd;
  assign wb_data    = r_wbData;
  assign store_done = r_storeDone;
  assign err_valid  = r_errValid;
  assign err_addr   = r_errAddr;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic compared against a byte-array reference memory.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done;
  logic        err_valid;
  logic [31:0] err_addr;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] refMem [1024];

  load_store_unit #(
    .MEM_WORDS (256),
    .ADDR_W    (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .store_done   (store_done),
    .err_valid    (err_valid),
    .err_addr     (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic bit modelErr(input bit isStore, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    int unsigned size;
    if (isStore) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else         legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = 1 << f3[1:0];
    return !legal || ((addr % size) != 0) || (addr >= 32'd1024);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    logic [9:0]  a;
    logic [7:0]  b;
    logic [15:0] h;
    a = addr[9:0];
    b = refMem[a];
    h = {refMem[a + 10'd1], refMem[a]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'b0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'b0, h};
      default: return {refMem[a + 10'd3], refMem[a + 10'd2], refMem[a + 10'd1], refMem[a]};
    endcase
  endfunction

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned size;
    size = 1 << f3[1:0];
    for (int i = 0; i < int'(size); i++) begin
      refMem[addr[9:0] + 10'(i)] = wdata[8*i +: 8];
    end
  endtask

  // Issue one request from a negedge in IDLE and verify the complete response timeline.
  task automatic applyStimulus(input bit isStore, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd);
    bit expErr;
    logic [31:0] expData;
    expErr = modelErr(isStore, f3, addr);
    expData = modelLoad(f3, addr);
    checkOutput("ready_before_req", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_store = isStore;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("err_valid_n1", 32'(err_valid), 32'(expErr));
    checkOutput("store_done_n1", 32'(store_done), 32'(isStore && !expErr));
    checkOutput("wb_valid_n1", 32'(wb_valid), 32'd0);
    checkOutput("ready_n1", 32'(req_ready), (!isStore && !expErr) ? 32'd0 : 32'd1);
    if (expErr) checkOutput("err_addr", err_addr, addr);
    if (isStore && !expErr) modelStore(f3, addr, wdata);
    if (!isStore && !expErr) begin
      @(negedge clk);
      checkOutput("wb_valid_n2", 32'(wb_valid), 32'd1);
      checkOutput("wb_rd_n2", 32'(wb_rd), 32'(rd));
      checkOutput("wb_data_n2", wb_data, expData);
      checkOutput("ready_n2", 32'(req_ready), 32'd1);
      checkOutput("no_other_pulse_n2", 32'(err_valid | store_done), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          isStore;
    int          r;
    logic [2:0]  legalLoads [5];
    legalLoads = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset = 1'b1;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    req_rd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_store_done", 32'(store_done), 32'd0);
    checkOutput("reset_err_valid", 32'(err_valid), 32'd0);
    checkOutput("reset_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    checkOutput("reset_err_addr", err_addr, 32'd0);

    // Fill the whole RAM so every later load has a known reference value.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 3'd2, 32'(i * 4), $urandom, 5'd0);
    end

    $display("[TB] directed scenarios");
    applyStimulus(1'b1, 3'd2, 32'h10, 32'h12345678, 5'd0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd5);
    applyStimulus(1'b1, 3'd0, 32'h13, 32'h000000AA, 5'd0);
    applyStimulus(1'b0, 3'd0, 32'h13, 32'h0, 5'd6);
    applyStimulus(1'b0, 3'd4, 32'h13, 32'h0, 5'd7);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd8);
    checkOutput("plan_lw_after_sb", modelLoad(3'd2, 32'h10), 32'hAA345678);
    applyStimulus(1'b1, 3'd1, 32'h12, 32'h0000BEEF, 5'd0);
    applyStimulus(1'b0, 3'd1, 32'h12, 32'h0, 5'd9);
    applyStimulus(1'b0, 3'd5, 32'h12, 32'h0, 5'd10);
    applyStimulus(1'b0, 3'd2, 32'h11, 32'h0, 5'd11);
    applyStimulus(1'b1, 3'd1, 32'h401, 32'h1234, 5'd0);
    applyStimulus(1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 5'd0);
    applyStimulus(1'b0, 3'd2, 32'h0, 32'h0, 5'd12);
    applyStimulus(1'b0, 3'd2, 32'h3FC, 32'h0, 5'd0);
    applyStimulus(1'b0, 3'd3, 32'h20, 32'h0, 5'd13);
    applyStimulus(1'b1, 3'd4, 32'h20, 32'h55, 5'd0);

    // Back-to-back loads with req_valid held high.
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'h10;
    req_rd = 5'd3;
    @(posedge clk);
    #1;
    req_addr = 32'h20;
    req_rd = 5'd4;
    @(negedge clk);
    checkOutput("b2b_ready_n1", 32'(req_ready), 32'd0);
    checkOutput("b2b_wb_valid_n1", 32'(wb_valid), 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_n2", 32'(req_ready), 32'd1);
    checkOutput("b2b_wb_valid_n2", 32'(wb_valid), 32'd1);
    checkOutput("b2b_wb_rd_n2", 32'(wb_rd), 32'd3);
    checkOutput("b2b_wb_data_n2", wb_data, modelLoad(3'd2, 32'h10));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_wb_valid_n3", 32'(wb_valid), 32'd0);
    checkOutput("b2b_ready_n3", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b_wb_valid_n4", 32'(wb_valid), 32'd1);
    checkOutput("b2b_wb_rd_n4", 32'(wb_rd), 32'd4);
    checkOutput("b2b_wb_data_n4", wb_data, modelLoad(3'd2, 32'h20));

    // Reset while the load is in its data cycle.
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_funct3 = 3'd2;
    req_addr = 32'h10;
    req_rd = 5'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_ld_ready_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ld_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_ld_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    checkOutput("rst_ld_wb_valid_after", 32'(wb_valid), 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd7);

    // Request coinciding with reset must be dropped.
    reset = 1'b1;
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'h10;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_store_done", 32'(store_done), 32'd0);
    checkOutput("rst_req_err_valid", 32'(err_valid), 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 5'd1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      isStore = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 9));
      if (r < 7) f3 = isStore ? 3'($urandom_range(0, 2)) : legalLoads[$urandom_range(0, 4)];
      else       f3 = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      if (r < 7)      addr = 32'($urandom_range(0, 1023));
      else if (r < 9) addr = 32'($urandom_range(1016, 1031));
      else            addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      applyStimulus(isStore, f3, addr, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
